pdm_word_decimator: RTL

- Consumes the 16-bit PDM words and one-cycle `done` strobes produced by the microphone deserializer stage.
- For each word, computes its population count (number of 1 bits) and sums those counts over `DECIM` consecutive words.
- Converts each completed sum to a signed PCM sample.
- Buffers samples in a small FIFO and presents them downstream on a valid/ready interface, ahead of the memory-write stage.

---
 rtl/pdm_word_decimator.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pdm_word_decimator.sv
// rtl/pdm_word_decimator.sv - PDM word popcount decimator with sample FIFO
// Sums popcounts over DECIM words, emits signed PCM samples on valid/ready.
module pdm_word_decimator #(
   parameter int DECIM      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int PCM_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             in_done,
   input  logic [15:0]      in_data,
   output logic [PCM_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow,
   input  logic             clear_ovf
);

   localparam int ACC_W = $clog2(16 * DECIM + 1);
   localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);

   function automatic logic [4:0] popcount16(input logic [15:0] w);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) begin
         c = c + 5'(w[i]);
      end
      return c;
   endfunction

   logic [4:0]       pop_q;
   logic             pop_v;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [ACC_W-1:0] sum_w;
   logic [PCM_W-1:0] sample;
   logic             last_word;
   logic             push;

   logic [PCM_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             empty;
   logic             full;
   logic             do_pop;
   logic             do_push;
   logic             drop;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pop_q <= '0;
         pop_v <= 1'b0;
      end else if (enable && in_done) begin
         pop_q <= popcount16(in_data);
         pop_v <= 1'b1;
      end else begin
         pop_v <= 1'b0;
      end
   end

   assign last_word = (cnt == CNT_W'(DECIM - 1));
   assign sum_w     = acc + ACC_W'(pop_q);
   // 2*sum - 16*DECIM maps the all-zero window to the most negative sample
   assign sample    = (PCM_W'(sum_w) << 1) - PCM_W'(16 * DECIM);
   assign push      = enable && pop_v && last_word;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc <= '0;
         cnt <= '0;
      end else if (!enable) begin
         acc <= '0;
         cnt <= '0;
      end else if (pop_v) begin
         if (last_word) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= sum_w;
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = !empty && out_ready;
   // A pop on the same edge frees the head slot, so a full FIFO can still accept
   assign do_push = push && (!full || do_pop);
   assign drop    = push && full && !do_pop;

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= sample;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clear_ovf) begin
         overflow <= 1'b0;
      end
   end

   assign out_valid = !empty;
   assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
